// File: rtl/write_select_decoder_pkg.sv
// Shared types and sizing for the register-file write-select decoder.
package write_select_decoder_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_addr_decoder.sv
// Combinational binary-index to one-hot decoder.
module onehot_addr_decoder
  import write_select_decoder_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot_c
);

  always_comb begin
    onehot_c = NUM_REGS'(1) << addr;
  end

endmodule

// File: rtl/write_select_decoder.sv
// Registered one-hot write-enable generator with a sequential clear sweep
// that walks every writable register once.
module write_select_decoder
  import write_select_decoder_pkg::*;
#(
  parameter int unsigned ZERO_REG_HW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_in,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic                clr_req,
  output logic [NUM_REGS-1:0] we_out,
  output logic                we_none,
  output logic                busy,
  output logic                clr_done,
  output logic                err
);

  localparam logic [ADDR_W-1:0] SWEEP_START = (ZERO_REG_HW != 0) ? ADDR_W'(1) : ADDR_W'(0);
  localparam logic [ADDR_W-1:0] SWEEP_LAST  = ADDR_W'(NUM_REGS - 1);

  state_e              state, state_nx;
  logic [ADDR_W-1:0]   ptr, ptr_nx;
  logic [ADDR_W-1:0]   dec_addr_c;
  logic [NUM_REGS-1:0] dec_onehot_c;
  logic [NUM_REGS-1:0] we_out_nx;
  logic                we_none_nx, busy_nx, clr_done_nx, err_nx;
  logic                addr_blocked_c;

  // Single decoder shared by the write path and the sweep pointer.
  onehot_addr_decoder u_dec (
    .addr     (dec_addr_c),
    .onehot_c (dec_onehot_c)
  );

  assign dec_addr_c     = (state == CLEAR) ? ptr : addr_in;
  assign addr_blocked_c = (ZERO_REG_HW != 0) && (addr_in == '0);

  // State and sweep pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // Next-state and pointer logic; the pointer stops at the last register.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
          ptr_nx   = SWEEP_START;
        end
      end
      CLEAR: begin
        if (ptr == SWEEP_LAST) begin
          state_nx = DONE;
        end else begin
          ptr_nx = ptr + ADDR_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        ptr_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        ptr_nx   = '0;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    we_out_nx   = '0;
    clr_done_nx = 1'b0;
    err_nx      = err;
    busy_nx     = (state_nx != IDLE) || (state == DONE);
    case (state)
      IDLE: begin
        if (clr_req) begin
          // Accepted clear drops the old error; a colliding write re-sets it.
          err_nx = we_in;
        end else if (we_in && !addr_blocked_c) begin
          we_out_nx = dec_onehot_c;
        end
      end
      CLEAR: begin
        we_out_nx = dec_onehot_c;
        if (we_in) begin
          err_nx = 1'b1;
        end
      end
      DONE: begin
        clr_done_nx = 1'b1;
        if (we_in) begin
          err_nx = 1'b1;
        end
      end
      default: begin
        we_out_nx = '0;
      end
    endcase
    we_none_nx = (we_out_nx == '0);
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_out   <= '0;
      we_none  <= 1'b1;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      we_out   <= we_out_nx;
      we_none  <= we_none_nx;
      busy     <= busy_nx;
      clr_done <= clr_done_nx;
      err      <= err_nx;
    end
  end

endmodule

// File: doc/write_select_decoder.md
WRITE_SELECT_DECODER -- requirements
Module: write_select_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of CLK.
REQ-002 Parameter SHALL be: NUM_REGS, 32, number of one-hot enable lines; ADDR_W = 5.
REQ-003 Parameter SHALL be: ZERO_REG_HW, 1, when 1 enable bit 0 is never asserted (register 0 hardwired).
REQ-004 Port SHALL be: CLK  input  1  rising-edge clock.
REQ-005 Port SHALL be: RST  input  1  synchronous active-high reset.
REQ-006 Port SHALL be: WE_IN  input  1  write request for ADDR_IN this cycle.
REQ-007 Port SHALL be: ADDR_IN  input  5  binary register index.
REQ-008 Port SHALL be: CLR_REQ  input  1  request to clear-sweep all writable registers.
REQ-009 Port SHALL be: WE_OUT  output  32  registered one-hot write enable.
REQ-010 Port SHALL be: WE_NONE  output  1  registered; 1 when WE_OUT is all zero.
REQ-011 Port SHALL be: BUSY  output  1  registered; 1 while a clear sweep is in progress.
REQ-012 Port SHALL be: CLR_DONE  output  1  registered one-cycle pulse at end of sweep.
REQ-013 Port SHALL be: ERR  output  1  sticky; a write request was discarded.

Function
REQ-014 FSM states SHALL be IDLE, CLEAR, DONE.
REQ-015 IDLE, CLR_REQ=0: next WE_OUT = WE_IN ? one-hot(ADDR_IN) : 0; latency exactly 1 cycle.
REQ-016 With ZERO_REG_HW=1, WE_IN with ADDR_IN=0 SHALL give WE_OUT=0 and WE_NONE=1, with ERR unaffected.
REQ-017 IDLE, CLR_REQ=1: next state CLEAR, sweep pointer = 1 (ZERO_REG_HW=1) or 0; BUSY=1 from next cycle.
REQ-018 CLR_REQ and WE_IN both high in IDLE: clear wins, write discarded, ERR set.
REQ-019 CLEAR: each cycle WE_OUT = one-hot(pointer), pointer +1; after pointer=31 is output, next state DONE.
REQ-020 Sweep SHALL produce exactly 31 (ZERO_REG_HW=1) or 32 consecutive non-zero WE_OUT cycles, ascending.
REQ-021 CLEAR or DONE: WE_IN=1 SHALL be discarded and set ERR; CLR_REQ SHALL be ignored.
REQ-022 DONE: WE_OUT=0, WE_NONE=1, CLR_DONE=1, BUSY=1 for exactly one cycle; then IDLE.
REQ-023 CLR_REQ held high through DONE SHALL start a new sweep from the IDLE cycle following DONE.
REQ-024 ERR SHALL clear only on RST or on acceptance of a new CLR_REQ in IDLE (set wins if same cycle).
REQ-025 Pointer SHALL be 5 bits; no wrap past 31 is permitted.
REQ-026 WE_OUT SHALL never have more than one bit set.

Reset
REQ-027 On RST: state IDLE, pointer 0, WE_OUT 0, WE_NONE 1, BUSY 0, CLR_DONE 0, ERR 0.
REQ-028 RST mid-sweep SHALL abort: the following cycle WE_OUT=0, and no CLR_DONE is issued.
REQ-029 RST SHALL override WE_IN and CLR_REQ in the same cycle.

Structure
REQ-030 A shared package SHALL hold the state enumeration, NUM_REGS, and ADDR_W.
REQ-031 A combinational sub-module onehot_addr_decoder (5-bit in, 32-bit one-hot out) SHALL be used for both the ADDR_IN and pointer paths, via a mux ahead of it.

Verification
REQ-032 RST, then WE_IN=1, ADDR_IN=5 -> next cycle WE_OUT=0x00000020, WE_NONE=0; the cycle after with WE_IN=0 -> WE_OUT=0, WE_NONE=1.
REQ-033 WE_IN=1, ADDR_IN=0 (ZERO_REG_HW=1) -> WE_OUT=0, WE_NONE=1, ERR=0.
REQ-034 CLR_REQ pulse -> 31 cycles WE_OUT=0x2, 0x4 ... 0x80000000, then one cycle CLR_DONE=1 with WE_OUT=0, then BUSY=0.
REQ-035 WE_IN=1, ADDR_IN=7 during sweep cycle 10 -> sweep unchanged, no 0x80 outside its slot, ERR=1 until next accepted CLR_REQ.
REQ-036 RST asserted at sweep cycle 15 -> WE_OUT=0, BUSY=0, no CLR_DONE; a subsequent WE_IN=1, ADDR_IN=3 -> WE_OUT=0x8.
REQ-037 CLR_REQ and WE_IN (ADDR_IN=9) together in IDLE -> sweep starts, ERR=1, bit 9 asserted only in sweep slot 9.
